// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction FIFO between fetch and decode.
// It absorbs fetch bursts and isolates fetch from decode stalls caused by
// dispatch back-pressure. It presents one {inst, pc} entry per cycle to the
// decoder. Branch mispredict and exception recovery squash it through flush.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous, active-high; empties the buffer
//   flush      synchronous squash of all entries; has priority over enq/deq
//   in_valid   fetch presents an instruction
//   in_inst    fetched instruction word
//   in_pc      PC of in_inst
//   in_ready   buffer can accept an entry this cycle (~full)
//   out_valid  head entry valid (~empty)
//   out_inst   head instruction
//   out_pc     head PC
//   out_ready  decode consumes the head this cycle
//   count      number of occupied entries
//   full       count == DEPTH
//   empty      count == 0
module inst_buffer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned XLEN  = 32,
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   output logic              in_ready,
   output logic              out_valid,
   output logic [31:0]       out_inst,
   output logic [XLEN-1:0]   out_pc,
   input  logic              out_ready,
   output logic [PTR_W:0]    count,
   output logic              full,
   output logic              empty
);

   localparam int unsigned        CW       = PTR_W + 1;
   localparam logic [CW-1:0]      FULL_CNT = CW'(DEPTH);

   logic [31:0]      mem_inst [DEPTH];
   logic [XLEN-1:0]  mem_pc   [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             enq;
   logic             deq;

   // Status is derived only from the registered count. A dequeue in the same
   // cycle therefore never frees a slot for a same-cycle enqueue when full.
   always_comb begin
      full      = (count == FULL_CNT);
      empty     = (count == '0);
      in_ready  = ~full;
      out_valid = ~empty;
      enq       = in_valid & in_ready;
      deq       = out_valid & out_ready;
      out_inst  = mem_inst[head];
      out_pc    = mem_pc[head];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PTR_W'(1);
         if (deq) head <= head + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage has no reset: its contents are don't-care until written.
   always_ff @(posedge clock) begin
      if (enq && !flush && !reset) begin
         mem_inst[tail] <= in_inst;
         mem_pc[tail]   <= in_pc;
      end
   end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Circular FIFO between the instruction fetch stage and the decoder.
- Absorbs fetch bursts and decouples fetch from decode stalls caused by dispatch back-pressure (RS/ROB full).
- Presents one {inst, pc} entry per cycle to the decoder's in_valid / inst / in_pc inputs.
- Flushed on branch mispredict or exception recovery.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high; clears buffer.
- flush  input  1  synchronous squash of all entries (mispredict/exception).
- in_valid  input  1  fetch presents a valid instruction.
- in_inst  input  32  fetched instruction word (INST).
- in_pc  input  XLEN  PC of in_inst.
- in_ready  output  1  buffer can accept an entry this cycle.
- out_valid  output  1  head entry valid; drives decoder in_valid.
- out_inst  output  32  head instruction; drives decoder inst.
- out_pc  output  XLEN  head PC; drives decoder in_pc.
- out_ready  input  1  decode/dispatch consumes head this cycle.
- count  output  PTR_W+1  number of occupied entries.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage: DEPTH x {inst[31:0], pc[XLEN-1:0]} registers, head pointer, tail pointer (PTR_W bits, wrap modulo DEPTH), count register (PTR_W+1 bits).
- enq = in_valid & in_ready; deq = out_valid & out_ready.
- in_ready = ~full. It is derived from registered count only; a same-cycle deq does not free space for a same-cycle enq when full.
- out_valid = ~empty. out_inst/out_pc = mem[head], combinational read of registered state. No bypass: an entry written at edge N is visible at out_* after edge N (1-cycle enqueue-to-output latency).
- On enq: mem[tail] <= {in_inst, in_pc}; tail <= tail+1.
- On deq: head <= head+1.
- Count update: count <= count + enq - deq. Simultaneous enq and deq leaves count unchanged; both pointers advance.
- Wrap-around: pointers roll from DEPTH-1 to 0; ordering is strict FIFO across the wrap.
- out_ready while empty: ignored, no state change. in_valid while full: ignored, and fetch must hold the entry.
- flush (highest synchronous priority): head <= 0, tail <= 0, count <= 0. Any enq or deq in the same cycle is discarded. in_ready is 1 and out_valid is 0 from the next cycle. Storage contents need not be cleared.
- reset (async, overrides all): head = tail = count = 0. Outputs immediately: out_valid=0, empty=1, full=0, in_ready=1, count=0. out_inst/out_pc are don't-care while out_valid=0. Storage is optionally zeroed.
- Reset asserted mid-burst discards all entries; operation resumes on the first edge after deassertion.
- No X propagation on out_valid / in_ready / count under any input sequence.

Test Plan:
- Reset then idle -> out_valid=0, empty=1, in_ready=1, count=0. Enq {0x00500093, pc 0x0} with out_ready=0 -> next cycle out_valid=1, out_inst=0x00500093, out_pc=0x0, count=1.
- Enq 8 sequential insts (pc 0x0..0x1C) with out_ready=0 -> full=1, in_ready=0, count=8. A 9th in_valid is not accepted. Drain with out_ready=1 -> pcs emerge in order 0x0..0x1C, then empty=1.
- Simultaneous enq/deq steady state at count=3 for 20 cycles (pointers wrap more than twice) -> count stays 3, output pc sequence strictly increasing by 4 with no gaps or duplicates.
- Full buffer, out_ready=1 and in_valid=1 in the same cycle -> head dequeued, new entry not accepted (in_ready=0), count=7. Next cycle in_ready=1.
- count=5, assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1, flushed entry not stored. A subsequent enq of pc 0x100 appears as the next output.
- Assert reset asynchronously between edges at count=4 -> out_valid, count and full drop to 0 immediately without waiting for a clock edge. After deassertion, normal enqueue resumes.
